// File: rtl/vec_op_requant.sv
// ============================================================================
// Module   : vec_op_requant
// Purpose  : Per-channel rounding right-shift requantizer, CORDIC_WIDTH ->
//            DATA_WIDTH, behind a valid/ready output register plus a one-entry
//            skid register (latency 1, full throughput).
// Ports    : clk, nreset (async, active-low)
//            in_vld / in_rdy / x_in / shift     : input word handshake
//            out_vld / out_rdy / x_out          : output word handshake
//            ovf_sticky / ovf_clr               : saturation sticky flag
// Options  : `define VEC_OP_REQUANT_SAT_EN -> saturate out-of-range results and
//            flag them; undefined -> keep the low DATA_WIDTH bits (wrap) and
//            ovf_sticky is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_op_requant #(
  parameter int CORDIC_WIDTH = 22,
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CH       = 4,
  parameter int SHIFT_W      = 3
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [NUM_CH*CORDIC_WIDTH-1:0] x_in,
  input  logic [SHIFT_W-1:0]           shift,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [NUM_CH*DATA_WIDTH-1:0] x_out,
  output logic                         ovf_sticky,
  input  logic                         ovf_clr
);

  localparam int MAX_S = CORDIC_WIDTH - DATA_WIDTH;
  // One guard bit above the input width so the rounding add cannot overflow.
  localparam int RW    = CORDIC_WIDTH + 1;
  localparam int OW    = NUM_CH * DATA_WIDTH;

  // ---------------------------------------------------------------------------
  // Requantization datapath (combinational, applied to the incoming word)
  // ---------------------------------------------------------------------------
  logic [SHIFT_W-1:0] s_eff;
  logic [OW-1:0]      q_word;

  always_comb begin
    s_eff = shift;
    if (int'({1'b0, shift}) > MAX_S) s_eff = SHIFT_W'(MAX_S);
  end

`ifdef VEC_OP_REQUANT_SAT_EN
  logic [NUM_CH-1:0] ch_sat;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic signed [RW-1:0]  ext;
    logic signed [RW-1:0]  rnd;
    logic signed [RW-1:0]  sum;
    logic signed [RW-1:0]  r;
    logic [DATA_WIDTH-1:0] q;

    always_comb begin
      ext = {x_in[k*CORDIC_WIDTH+CORDIC_WIDTH-1], x_in[k*CORDIC_WIDTH +: CORDIC_WIDTH]};
      rnd = '0;
      if (s_eff != '0) rnd = RW'(1) << (s_eff - SHIFT_W'(1));
      sum = ext + rnd;
      r   = sum >>> s_eff;
    end

`ifdef VEC_OP_REQUANT_SAT_EN
    // In range iff every bit from the result MSB down to the output sign bit
    // agrees; otherwise clamp toward the sign of r.
    logic [RW-DATA_WIDTH:0] hi;
    logic                   sat;
    always_comb begin
      hi  = r[RW-1:DATA_WIDTH-1];
      sat = !((&hi) || (~|hi));
      q   = r[DATA_WIDTH-1:0];
      if (sat) q = r[RW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                           : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
    assign ch_sat[k] = sat;
`else
    logic unused_hi;
    assign q         = r[DATA_WIDTH-1:0];
    assign unused_hi = ^r[RW-1:DATA_WIDTH];
`endif

    assign q_word[k*DATA_WIDTH +: DATA_WIDTH] = q;
  end

  // ---------------------------------------------------------------------------
  // Output register + skid register
  // ---------------------------------------------------------------------------
  logic          out_vld_q, out_vld_d;
  logic [OW-1:0] out_data_q, out_data_d;
  logic          skid_vld_q, skid_vld_d;
  logic [OW-1:0] skid_data_q, skid_data_d;
  logic          accept;
  logic          main_free;

`ifdef VEC_OP_REQUANT_SAT_EN
  logic skid_sat_q, skid_sat_d;
  logic sticky_q, sticky_d;
  logic load_sat;
`endif

  assign in_rdy    = ~skid_vld_q;
  assign accept    = in_vld & in_rdy;
  assign main_free = ~out_vld_q | out_rdy;

  always_comb begin
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
`ifdef VEC_OP_REQUANT_SAT_EN
    skid_sat_d  = skid_sat_q;
    load_sat    = 1'b0;
`endif
    if (main_free) begin
      // in_rdy is low while the skid holds a word, so accept and skid_vld
      // are never both set here.
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_data_d = skid_data_q;
        skid_vld_d = 1'b0;
`ifdef VEC_OP_REQUANT_SAT_EN
        load_sat   = skid_sat_q;
`endif
      end else if (accept) begin
        out_vld_d  = 1'b1;
        out_data_d = q_word;
`ifdef VEC_OP_REQUANT_SAT_EN
        load_sat   = |ch_sat;
`endif
      end else begin
        out_vld_d  = 1'b0;
      end
    end else if (accept) begin
      skid_vld_d  = 1'b1;
      skid_data_d = q_word;
`ifdef VEC_OP_REQUANT_SAT_EN
      skid_sat_d  = |ch_sat;
`endif
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
    end else begin
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef VEC_OP_REQUANT_SAT_EN
  // A saturating load in the same cycle as a clear leaves the flag set.
  assign sticky_d = (sticky_q & ~ovf_clr) | load_sat;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      skid_sat_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      skid_sat_q <= skid_sat_d;
      sticky_q   <= sticky_d;
    end
  end

  assign ovf_sticky = sticky_q;
`else
  logic unused_clr;
  assign unused_clr = ovf_clr;
  assign ovf_sticky = 1'b0;
`endif

  assign out_vld = out_vld_q;
  assign x_out   = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_vec_op_requant.sv
// ============================================================================
// Module   : tb_vec_op_requant
// Purpose  : Self-checking bench for vec_op_requant: scoreboard of expected
//            words filled on input transfers, drained on output transfers,
//            plus directed checks of rounding, clamping, saturation,
//            backpressure and reset behaviour.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vec_op_requant;

  localparam int CW   = 22;
  localparam int DW   = 16;
  localparam int NCH  = 4;
  localparam int SW   = 3;
  localparam int MAXS = CW - DW;
`ifdef VEC_OP_REQUANT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               nreset;
  logic               in_vld;
  logic               in_rdy;
  logic [NCH*CW-1:0]  x_in;
  logic [SW-1:0]      shift;
  logic               out_vld;
  logic               out_rdy;
  logic [NCH*DW-1:0]  x_out;
  logic               ovf_sticky;
  logic               ovf_clr;

  vec_op_requant #(
    .CORDIC_WIDTH (CW),
    .DATA_WIDTH   (DW),
    .NUM_CH       (NCH),
    .SHIFT_W      (SW)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .x_in       (x_in),
    .shift      (shift),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .x_out      (x_out),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt  = 0;
  int out_cnt  = 0;
  logic [NCH*DW-1:0] exp_q[$];
  logic              hold_vld = 1'b0;
  logic [NCH*DW-1:0] hold_val;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: round half toward +inf, arithmetic shift, then clamp or wrap.
  function automatic logic [NCH*DW-1:0] ref_word(input logic [NCH*CW-1:0] x, input logic [SW-1:0] sh);
    int     s;
    longint xv, r, hi, lo;
    logic [NCH*DW-1:0] w;
    s  = (int'(sh) > MAXS) ? MAXS : int'(sh);
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -hi - 1;
    w  = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      xv = longint'($signed(x[ch*CW +: CW]));
      if (s == 0) r = xv;
      else        r = (xv + (longint'(1) << (s - 1))) >>> s;
      if (SAT && r > hi) r = hi;
      if (SAT && r < lo) r = lo;
      w[ch*DW +: DW] = r[DW-1:0];
    end
    return w;
  endfunction

  function automatic logic [NCH*CW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [NCH*CW-1:0] v;
    v[0*CW +: CW] = CW'(a);
    v[1*CW +: CW] = CW'(b);
    v[2*CW +: CW] = CW'(c);
    v[3*CW +: CW] = CW'(d);
    return v;
  endfunction

  // Monitor at the falling edge: handshake values here are what the next
  // rising edge will act on.
  always @(negedge clk) begin
    if (!nreset) begin
      exp_q.delete();
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        check_val("hold_vld", 64'(out_vld), 64'd1);
        check_val("hold_data", 64'(x_out), 64'(hold_val));
      end
      if (in_vld && in_rdy) begin
        exp_q.push_back(ref_word(x_in, shift));
        acc_cnt++;
      end
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) check_val("spurious_out", 64'd1, 64'd0);
        else                   check_val("sb_data", 64'(x_out), 64'(exp_q.pop_front()));
        out_cnt++;
      end
      hold_vld = out_vld && !out_rdy;
      hold_val = x_out;
    end
  end

  // All driver tasks start and end just after a rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [NCH*CW-1:0] x, input logic [SW-1:0] sh);
    logic ok;
    ok     = 1'b0;
    in_vld = 1'b1;
    x_in   = x;
    shift  = sh;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      ok = in_rdy;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) check_val("send_timeout", 64'd0, 64'd1);
    in_vld = 1'b0;
  endtask

  // Returns at a falling edge with out_vld high, or flags a timeout.
  task automatic wait_out(input string tag);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (out_vld) return;
    end
    check_val({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  logic [NCH*CW-1:0] xa, xb;
  logic [NCH*DW-1:0] e0;
  int base, cyc;

  initial begin
    nreset  = 1'b0;
    in_vld  = 1'b0;
    x_in    = '0;
    shift   = '0;
    out_rdy = 1'b0;
    ovf_clr = 1'b0;
    repeat (3) cycle();
    check_val("rst_in_rdy", 64'(in_rdy), 64'd1);
    nreset = 1'b1;

    // Idle after reset release
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("idle_out_vld", 64'(out_vld), 64'd0);
    end
    check_val("idle_x_out", 64'(x_out), 64'd0);
    check_val("idle_sticky", 64'(ovf_sticky), 64'd0);
    check_val("idle_in_rdy", 64'(in_rdy), 64'd1);
    cycle();

    // Legacy rounding: 63 -> 1, -32 -> 0, -33 -> -1, 0 -> 0
    out_rdy = 1'b1;
    xa = pack4(63, -32, -33, 0);
    send(xa, 3'd6);
    wait_out("legacy");
    check_val("legacy_s6", 64'(x_out), {16'h0000, 16'hFFFF, 16'h0000, 16'h0001});
    cycle();
    send(xa, 3'd7);
    wait_out("clamp");
    check_val("legacy_s7", 64'(x_out), {16'h0000, 16'hFFFF, 16'h0000, 16'h0001});
    cycle();

    // Saturation, shift 0: only channel 0 is out of range
    send(pack4(32'h1FFFFF, 5, -7, 100), 3'd0);
    wait_out("sat");
    check_val("sat_s0", 64'(x_out), {16'd100, 16'hFFF9, 16'd5, (SAT ? 16'h7FFF : 16'hFFFF)});
    check_val("sat_sticky", 64'(ovf_sticky), 64'(SAT));
    cycle();
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    @(negedge clk);
    check_val("sticky_clr", 64'(ovf_sticky), 64'd0);
    cycle();

    // Shift 7 clamped to 6, saturating channel 0, channel 3 in range;
    // clear asserted on the same edge as the saturating load.
    ovf_clr = 1'b1;
    send(pack4(32'h1FFFFF, 0, 0, 63), 3'd7);
    ovf_clr = 1'b0;
    wait_out("sat7");
    check_val("sat_s7", 64'(x_out), {16'h0001, 16'h0000, 16'h0000, (SAT ? 16'h7FFF : 16'h8000)});
    check_val("sticky_set_wins", 64'(ovf_sticky), 64'(SAT));
    cycle();
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;

    // Backpressure: 8 words, output stalled for 5 cycles after the skid fills
    out_rdy = 1'b0;
    base    = out_cnt;
    send(pack4(1000, -1000, 2000, -2000), 3'd2);
    send(pack4(1001, -1001, 2001, -2001), 3'd2);
    e0 = ref_word(pack4(1000, -1000, 2000, -2000), 3'd2);
    in_vld = 1'b1;
    x_in   = pack4(1002, -1002, 2002, -2002);
    shift  = 3'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_in_rdy", 64'(in_rdy), 64'd0);
      check_val("bp_x_out", 64'(x_out), 64'(e0));
    end
    cycle();
    out_rdy = 1'b1;
    for (int i = 2; i < 8; i++) send(pack4(1000 + i, -1000 - i, 2000 + i, -2000 - i), 3'd2);
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) cycle();
    check_val("bp_count", 64'(out_cnt - base), 64'd8);

    // Reset while the skid is full
    out_rdy = 1'b0;
    send(pack4(11, 22, 33, 44), 3'd1);
    send(pack4(55, 66, 77, 88), 3'd1);
    nreset = 1'b0;
    @(negedge clk);
    check_val("rst_mid_x_out", 64'(x_out), 64'd0);
    check_val("rst_mid_in_rdy", 64'(in_rdy), 64'd1);
    cycle();
    nreset = 1'b1;
    repeat (3) cycle();
    @(negedge clk);
    check_val("rst_rel_out_vld", 64'(out_vld), 64'd0);
    check_val("rst_rel_in_rdy", 64'(in_rdy), 64'd1);
    cycle();
    out_rdy = 1'b1;
    xb = pack4(-500, 501, -502, 503);
    send(xb, 3'd3);
    wait_out("rst_next");
    check_val("rst_next_word", 64'(x_out), 64'(ref_word(xb, 3'd3)));
    cycle();

    // Random traffic against the reference model
    base = acc_cnt;
    cyc  = 0;
    while ((acc_cnt - base) < 10000 && cyc < 60000) begin
      in_vld = ($urandom_range(0, 3) != 0);
      for (int ch = 0; ch < NCH; ch++) x_in[ch*CW +: CW] = CW'($urandom);
      shift   = SW'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      cycle();
      cyc++;
    end
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) cycle();
    check_val("rand_accepted", 64'((acc_cnt - base) >= 10000), 64'd1);
    check_val("rand_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
